// File: rtl/mux4_rr_select.sv
// mux4_rr_select
//   Round-robin select generator for a 4-to-1 mux. Four channels raise
//   requests. One channel is granted at a time with rotating priority. The
//   select code is held until the downstream consumer takes the word.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] request per channel (bit k -> mux input ik)
//   ready  in   downstream accepts the current word
//   s1,s0  out  registered mux select (MSB, LSB)
//   gnt    out  [3:0] registered one-hot grant (or zero)
//   valid  out  registered: mux output carries a granted word
//
// Handshake: a word transfers on a rising edge where valid=1 and ready=1.
//   While valid=1 the outputs s1/s0/gnt/valid stay stable until that edge,
//   or until the granted channel drops its request while ready=0 (abort).
//   A ready seen while valid=0 is ignored.
//
// Parameter
//   PARK_ON_IDLE  1: select keeps the last granted code while idle
//                 0: select returns to 2'b00 whenever valid=0
module mux4_rr_select #(
  parameter bit PARK_ON_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ready,
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] idx, idx_n;
  logic [1:0] sel, sel_n;
  logic [3:0] gnt_n;
  logic       valid_n;

  // Arbiter: scan from arb_base upwards (mod 4), first requester wins.
  logic [1:0] arb_base;
  logic [1:0] arb_idx;
  logic [1:0] cand;
  logic       arb_hit;

  always_comb begin
    // On a completion the served channel becomes lowest priority in the
    // same edge, so the re-arbitration already uses the advanced pointer.
    arb_base = ptr;
    if (state == GRANT && ready) arb_base = idx + 2'd1;

    arb_hit = 1'b0;
    arb_idx = arb_base;
    cand    = arb_base;
    // Descending loop: the smallest offset from arb_base is written last.
    for (int i = 3; i >= 0; i--) begin
      cand = arb_base + 2'(i);
      if (req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    gnt_n   = gnt;
    valid_n = valid;

    case (state)
      IDLE: begin
        if (arb_hit) begin
          idx_n   = arb_idx;
          gnt_n   = 4'b0001 << arb_idx;
          valid_n = 1'b1;
          state_n = GRANT;
        end else begin
          gnt_n   = 4'b0000;
          valid_n = 1'b0;
        end
      end
      GRANT: begin
        if (ready) begin
          // Completion wins over abort when both apply.
          ptr_n = arb_base;
          if (arb_hit) begin
            idx_n   = arb_idx;
            gnt_n   = 4'b0001 << arb_idx;
            valid_n = 1'b1;
          end else begin
            gnt_n   = 4'b0000;
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end else if (!req[idx]) begin
          // Abort: grant withdrawn, priority pointer untouched.
          gnt_n   = 4'b0000;
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        gnt_n   = 4'b0000;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase

    if (PARK_ON_IDLE) sel_n = idx_n;
    else              sel_n = valid_n ? idx_n : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      idx   <= 2'd0;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      valid <= valid_n;
    end
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

endmodule

// File: doc/mux4_rr_select.md
# mux4_rr_select

Round-robin select generator that sits directly upstream of the 4-to-1 multiplexer and drives its `s1`/`s0` select lines. Four sources raise requests. The block grants one at a time with rotating priority and holds the select code stable until the downstream consumer accepts the word through a valid/ready handshake. It turns the purely combinational mux into a fair, flow-controlled 4-channel funnel.

## Interface
- `PARK_ON_IDLE`, default 1: when 1, `s1`/`s0` keep the last granted code while idle; when 0, they return to 2'b00 while idle.

Ports:
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst_n`  input  1  reset. One clock; reset is asynchronous and active-low.
- `req`  input  4  request per channel; bit k requests mux input `ik`.
- `ready`  input  1  downstream consumer accepts the current word.
- `s1`  output  1  mux select MSB (registered).
- `s0`  output  1  mux select LSB (registered).
- `gnt`  output  4  one-hot grant; bit k set when channel k owns the mux (registered).
- `valid`  output  1  mux output is a granted word (registered).

## Operation
- Internal state:
  - FSM state: IDLE or GRANT.
  - 2-bit priority pointer `ptr`.
  - 2-bit current index `idx`, which drives `s1`/`s0`.
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE, `ptr`=0, `idx`=0.
  - Outputs: `s1`=0, `s0`=0, `gnt`=4'b0000, `valid`=0.
  - Takes effect immediately, including mid-grant; no handshake completes.
- Arbitration function: starting at `ptr`, scan `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, wrapping mod 4. Select the first channel k with `req[k]`=1.
- IDLE:
  - If `req`≠0, at the next edge: `idx`=k, `gnt`=1<<k, `valid`=1, go to GRANT.
  - If `req`=0, stay in IDLE with `valid`=0 and `gnt`=0.
- GRANT: `s1`, `s0`, `gnt` and `valid` are held stable until one of the events below.
- Completion (`valid`=1 and `ready`=1 at the edge):
  - `ptr` <= `idx`+1 mod 4, so the served channel becomes lowest priority.
  - Re-arbitrate in the same edge using the new pointer and the current `req`.
  - If a winner exists, stay in GRANT and present the new grant the next cycle. There is no bubble, and `valid` stays 1.
  - Otherwise go to IDLE with `valid`=0 and `gnt`=0.
- Abort (`req[idx]`=0 and `ready`=0 at the edge):
  - Grant is withdrawn: go to IDLE, `valid`=0, `gnt`=0. `ptr` is unchanged.
  - Arbitration resumes from IDLE on the following edge.
- `ready`=1 together with `req[idx]`=0 in the same cycle counts as completion; completion has priority over abort.
- `ready` while `valid`=0 is ignored.
- Select behaviour while idle:
  - `PARK_ON_IDLE`=1: `s1`/`s0` retain `idx`.
  - `PARK_ON_IDLE`=0: `s1`/`s0` are forced to 0 whenever `valid`=0.
- `{s1,s0}` always equals the binary index of the set bit of `gnt` whenever `valid`=1.
- `gnt` is one-hot or zero; it is never multi-hot.

## Timing
- Latency from `req` asserted in IDLE to `valid`: 1 cycle (registered).
- Back-to-back throughput: one grant per cycle while `ready`=1 and requests remain.
- All outputs are registered; there is no combinational path from `req` or `ready` to any output.
- Fairness: a continuously requesting channel waits at most 3 completed transfers before being granted.

## Test plan
- Reset and single request:
  - Hold `rst_n`=0, then release. Check all outputs are 0.
  - Drive `req`=4'b0100. One edge later: `gnt`=4'b0100, `{s1,s0}`=2'b10, `valid`=1.
- Rotation:
  - Hold `req`=4'b1111 and `ready`=1 continuously.
  - Required grant sequence on consecutive cycles: ch0, ch1, ch2, ch3, ch0. `valid` stays 1 throughout with no gaps.
- Backpressure:
  - With `req`=4'b0011 and `ready`=0 for 5 cycles, `gnt` stays 4'b0001 and `s1`/`s0` stay 0.
  - Raise `ready` for one cycle; the next grant is 4'b0010.
- Abort:
  - Grant ch2, then drop `req[2]` with `ready`=0.
  - Next cycle: `valid`=0, `gnt`=0.
  - With `req`=4'b0110 the following cycle, ch1 is granted because `ptr` is still 0.
- Completion vs abort:
  - Grant ch3, then in the same cycle drop `req[3]` and assert `ready`=1.
  - This counts as a completion: `ptr`=0, and with `req`=4'b1001 the next grant is ch0.
- Asynchronous reset mid-grant:
  - Pulse `rst_n` low between clock edges while `valid`=1.
  - All outputs clear immediately, before the next edge; after release, arbitration restarts from ch0.
